// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if
// Bundles the requester handshake and the SPI pin signals of spi_master_arb.
//   req/wdata0/wdata1 : requester frame requests and their write words
//   gnt/done          : one-hot grant and end-of-frame pulses
//   rdata/busy        : last captured read word, frame-in-progress flag
//   sclk/ssn/mosi     : SPI pins driven by the master
//   miso              : SPI data in (already synchronised)
// Modports: slave = the arbiter/master block, master = requester/board side.
interface spi_master_arb_if #(
   parameter int DATA_W = 16
);
   logic [1:0]        req;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              sclk;
   logic              ssn;
   logic              mosi;
   logic              miso;

   modport slave (
      input  req, wdata0, wdata1, miso,
      output gnt, done, rdata, busy, sclk, ssn, mosi
   );

   modport master (
      output req, wdata0, wdata1, miso,
      input  gnt, done, rdata, busy, sclk, ssn, mosi
   );
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb
// SPI mode-0 master with a two-requester arbiter. One frame of DATA_W bits is
// shifted MSB-first on mosi while miso is captured into rdata.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (aborts any frame in flight)
//   bus   : spi_master_arb_if.slave (req, wdata0/1, gnt, done, rdata, busy,
//           sclk, ssn, mosi, miso)
// Configuration macro SPI_ARB_RR_EN: defined = round-robin arbitration,
// undefined = fixed priority with requester 0 first.
module spi_master_arb #(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = 10,
   parameter int GAP_CYC = 2
) (
   input  logic           clk,
   input  logic           reset,
   spi_master_arb_if.slave bus
);
   localparam int HALF  = CLK_DIV / 2;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_div
      $error("spi_master_arb: CLK_DIV must be even and >= 4");
   end
   if (GAP_CYC < 1) begin : g_bad_gap
      $error("spi_master_arb: GAP_CYC must be >= 1");
   end

   logic [1:0]        state_r;
   logic [DIV_W-1:0]  div_r;
   logic [4:0]        bit_r;
   logic [GAP_W-1:0]  gap_r;
   logic              phase_r;   // 1 = sclk high phase of the current bit
   logic [DATA_W-1:0] shift_r;
   logic [DATA_W-1:0] rshift_r;
   logic              winner_r;
   logic [1:0]        gnt_r;
   logic [1:0]        done_r;
   logic [DATA_W-1:0] rdata_r;
   logic              busy_r;
   logic              sclk_r;
   logic              ssn_r;
   logic              mosi_r;
`ifdef SPI_ARB_RR_EN
   logic              last_r;    // requester granted most recently
`endif

   logic              win_s;
   logic [DATA_W-1:0] win_data_s;
   logic              div_last_s;

   // Arbitration: pick the winning requester from the current req bits
   always_comb begin
      win_s = 1'b0;
      if (bus.req == 2'b11) begin
`ifdef SPI_ARB_RR_EN
         win_s = ~last_r;
`else
         win_s = 1'b0;
`endif
      end else if (bus.req == 2'b10) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   assign win_data_s = win_s ? bus.wdata1 : bus.wdata0;
   assign div_last_s = (div_r == DIV_W'(HALF - 1));

   // Frame sequencer, SPI shifter and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= IDLE;
         div_r    <= '0;
         bit_r    <= 5'd0;
         gap_r    <= '0;
         phase_r  <= 1'b0;
         shift_r  <= '0;
         rshift_r <= '0;
         winner_r <= 1'b0;
         gnt_r    <= 2'b00;
         done_r   <= 2'b00;
         rdata_r  <= '0;
         busy_r   <= 1'b0;
         sclk_r   <= 1'b0;
         ssn_r    <= 1'b1;
         mosi_r   <= 1'b0;
`ifdef SPI_ARB_RR_EN
         // "last granted = 1" makes requester 0 preferred after reset
         last_r   <= 1'b1;
`endif
      end else begin
         gnt_r  <= 2'b00;
         done_r <= 2'b00;
         case (state_r)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  state_r  <= SETUP;
                  shift_r  <= win_data_s;
                  rshift_r <= '0;
                  mosi_r   <= win_data_s[DATA_W-1];
                  winner_r <= win_s;
                  gnt_r    <= win_s ? 2'b10 : 2'b01;
                  busy_r   <= 1'b1;
                  ssn_r    <= 1'b0;
                  sclk_r   <= 1'b0;
                  div_r    <= '0;
`ifdef SPI_ARB_RR_EN
                  last_r   <= win_s;
`endif
               end
            end
            SETUP: begin
               if (div_last_s) begin
                  state_r <= SHIFT;
                  div_r   <= '0;
                  bit_r   <= 5'd0;
                  phase_r <= 1'b1;
                  sclk_r  <= 1'b1;
               end else begin
                  div_r <= div_r + DIV_W'(1);
               end
            end
            SHIFT: begin
               if (!div_last_s) begin
                  div_r <= div_r + DIV_W'(1);
               end else begin
                  div_r <= '0;
                  if (phase_r) begin
                     // End of high phase: sample miso, then falling edge
                     // advances mosi to the next bit (zero after the last).
                     rshift_r <= {rshift_r[DATA_W-2:0], bus.miso};
                     shift_r  <= {shift_r[DATA_W-2:0], 1'b0};
                     mosi_r   <= shift_r[DATA_W-2];
                     sclk_r   <= 1'b0;
                     phase_r  <= 1'b0;
                  end else if (bit_r == 5'(DATA_W - 1)) begin
                     state_r <= GAP;
                     gap_r   <= '0;
                     ssn_r   <= 1'b1;
                     mosi_r  <= 1'b0;
                     done_r  <= winner_r ? 2'b10 : 2'b01;
                     rdata_r <= rshift_r;
                  end else begin
                     bit_r   <= bit_r + 5'd1;
                     sclk_r  <= 1'b1;
                     phase_r <= 1'b1;
                  end
               end
            end
            GAP: begin
               if (gap_r == GAP_W'(GAP_CYC - 1)) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  gap_r <= gap_r + GAP_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               sclk_r  <= 1'b0;
               ssn_r   <= 1'b1;
               mosi_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt_r;
   assign bus.done  = done_r;
   assign bus.rdata = rdata_r;
   assign bus.busy  = busy_r;
   assign bus.sclk  = sclk_r;
   assign bus.ssn   = ssn_r;
   assign bus.mosi  = mosi_r;
endmodule

// File: tb/tb_spi_master_arb.sv
// tb_spi_master_arb
// Directed bench for spi_master_arb with default parameters: single frame,
// loopback, contention, request while busy and reset mid-frame.
module tb_spi_master_arb;
   logic clk = 1'b0;
   logic reset;

   spi_master_arb_if #(.DATA_W(16)) bus ();

   spi_master_arb dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // slave model: mode-0 slave shifting pat out MSB-first, or loopback
   logic        loop = 1'b0;
   logic [15:0] pat  = 16'h0000;
   int falls_total = 0;
   int falls_base  = 0;

   function automatic int miso_idx(input int falls);
      int i;
      i = 15 - falls;
      if (i < 0) i = 0;
      return i;
   endfunction

   always @(negedge bus.sclk) falls_total++;
   always @(negedge bus.ssn)  falls_base = falls_total;
   assign bus.miso = loop ? bus.mosi : pat[miso_idx(falls_total - falls_base)];

   // mosi captured at each sclk rise
   logic [15:0] mosi_cap = 16'h0000;
   int rises_total = 0;
   always @(posedge bus.sclk) begin
      mosi_cap = {mosi_cap[14:0], bus.mosi};
      rises_total++;
   end

   // cycle-level log of ssn-low time, grants and done pulses
   int cyc = 0;
   int ssn_low_total = 0;
   int done_total = 0;
   int last_done_cyc = 0;
   logic [1:0] gq[$];
   int gc[$];
   always @(posedge clk) begin
      cyc++;
      if (bus.ssn == 1'b0) ssn_low_total++;
      if (bus.gnt != 2'b00) begin
         gq.push_back(bus.gnt);
         gc.push_back(cyc);
      end
      if (bus.done != 2'b00) begin
         done_total++;
         last_done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (bus.done == 2'b00 && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_done_timeout"}, 32'(n < 400), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_idle_timeout"}, 32'(n < 400), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rb, sb, db, gb, n;
      logic [1:0] exp_g;

      reset      = 1'b1;
      bus.req    = 2'b00;
      bus.wdata0 = 16'h0000;
      bus.wdata1 = 16'h0000;
      repeat (3) tick();
      chk("rst_gnt",   32'(bus.gnt),   32'd0);
      chk("rst_done",  32'(bus.done),  32'd0);
      chk("rst_rdata", 32'(bus.rdata), 32'd0);
      chk("rst_busy",  32'(bus.busy),  32'd0);
      chk("rst_sclk",  32'(bus.sclk),  32'd0);
      chk("rst_ssn",   32'(bus.ssn),   32'd1);
      chk("rst_mosi",  32'(bus.mosi),  32'd0);
      reset = 1'b0;
      tick();

      // single frame from requester 0
      loop = 1'b0;
      pat  = 16'h3C5A;
      bus.wdata0 = 16'hA5C3;
      rb = rises_total;
      sb = ssn_low_total;
      bus.req = 2'b01;
      tick();
      chk("s_gnt",  32'(bus.gnt),  32'h1);
      chk("s_ssn",  32'(bus.ssn),  32'd0);
      chk("s_busy", 32'(bus.busy), 32'd1);
      bus.req = 2'b00;
      repeat (4) tick();
      chk("s_sclk_setup", 32'(bus.sclk), 32'd0);
      tick();
      chk("s_sclk_rise",  32'(bus.sclk), 32'd1);
      wait_done("s");
      chk("s_done",    32'(bus.done),  32'h1);
      chk("s_rdata",   32'(bus.rdata), 32'h3C5A);
      chk("s_ssn_hi",  32'(bus.ssn),   32'd1);
      chk("s_mosi",    32'(mosi_cap),  32'hA5C3);
      chk("s_rises",   32'(rises_total - rb),   32'd16);
      chk("s_ssn_len", 32'(ssn_low_total - sb), 32'd165);
      repeat (2) tick();
      chk("s_busy_end", 32'(bus.busy), 32'd0);

      // loopback from requester 1
      loop = 1'b1;
      bus.wdata1 = 16'h8001;
      rb = rises_total;
      bus.req = 2'b10;
      tick();
      chk("l_gnt", 32'(bus.gnt), 32'h2);
      bus.req = 2'b00;
      wait_done("l");
      chk("l_done",  32'(bus.done),  32'h2);
      chk("l_rdata", 32'(bus.rdata), 32'h8001);
      chk("l_rises", 32'(rises_total - rb), 32'd16);
      repeat (3) tick();
      chk("l_sclk_idle", 32'(bus.sclk), 32'd0);
      chk("l_busy",      32'(bus.busy), 32'd0);

      // contention: both requesters held high
      gb = gq.size();
      bus.req = 2'b11;
      n = 0;
      while ((gq.size() - gb) < 4 && n < 800) begin
         tick();
         n++;
      end
      bus.req = 2'b00;
      chk("c_timeout", 32'(n < 800), 32'd1);
      if (gq.size() - gb >= 4) begin
         for (int k = 0; k < 4; k++) begin
`ifdef SPI_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            chk($sformatf("c_gnt%0d", k), 32'(gq[gb + k]), 32'(exp_g));
            if (k > 0) begin
               chk($sformatf("c_space%0d", k), 32'(gc[gb + k] - gc[gb + k - 1]), 32'd168);
            end
         end
      end
      wait_idle("c");

      // request from requester 1 while requester 0 is mid-frame
      bus.wdata0 = 16'h1234;
      bus.req = 2'b01;
      tick();
      chk("b_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 2'b00;
      repeat (50) tick();
      bus.req = 2'b10;
      n = 0;
      while (bus.gnt == 2'b00 && n < 300) begin
         tick();
         n++;
      end
      chk("b_timeout", 32'(n < 300), 32'd1);
      chk("b_gnt1",  32'(bus.gnt),   32'h2);
      chk("b_rdata", 32'(bus.rdata), 32'h1234);
      tick();
      bus.req = 2'b00;
      chk("b_gap", 32'(gc[gc.size() - 1] - last_done_cyc), 32'd3);
      wait_done("b");
      chk("b_rdata1", 32'(bus.rdata), 32'h8001);
      wait_idle("b");

      // reset during bit 7
      loop = 1'b0;
      pat  = 16'h3C5A;
      bus.wdata0 = 16'hA5C3;
      bus.req = 2'b01;
      tick();
      chk("r_gnt", 32'(bus.gnt), 32'h1);
      bus.req = 2'b00;
      repeat (77) tick();
      db = done_total;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("r_ssn",   32'(bus.ssn),   32'd1);
      chk("r_sclk",  32'(bus.sclk),  32'd0);
      chk("r_busy",  32'(bus.busy),  32'd0);
      chk("r_rdata", 32'(bus.rdata), 32'd0);
      chk("r_done",  32'(bus.done),  32'd0);
      repeat (200) tick();
      chk("r_no_done", 32'(done_total - db), 32'd0);

      rb = rises_total;
      sb = ssn_low_total;
      bus.req = 2'b01;
      tick();
      chk("r2_gnt", 32'(bus.gnt), 32'h1);
      bus.req = 2'b00;
      wait_done("r2");
      chk("r2_done",    32'(bus.done),  32'h1);
      chk("r2_rdata",   32'(bus.rdata), 32'h3C5A);
      chk("r2_mosi",    32'(mosi_cap),  32'hA5C3);
      chk("r2_rises",   32'(rises_total - rb),   32'd16);
      chk("r2_ssn_len", 32'(ssn_low_total - sb), 32'd165);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/spi_master_arb.md
# spi_master_arb

SPI mode-0 master with a built-in two-requester arbiter, running on the 100 MHz system clock.
- Accepts 16-bit write words from two on-chip requesters and grants one frame at a time.
- Serialises each word MSB-first on `mosi` with a divided `sclk`, while capturing `miso` into a read word.
- Sits between the requesters and the board-level SPI pins, and drives the team's SPI slave block at 10 MHz with default parameters.

## Interface
Parameters:
- `DATA_W`, 16 — frame length in bits and width of all data ports.
- `CLK_DIV`, 10 — `sclk` period in `clk` cycles. Must be even and ≥4; elaboration fails otherwise. `HALF = CLK_DIV/2`.
- `GAP_CYC`, 2 — minimum `ssn`-high cycles between frames. Must be ≥1.

Ports:
- `clk` in 1 — system clock, 100 MHz.
- `reset` in 1 — synchronous, active-high reset.
- `req` in 2 — per-requester frame request, level. Held high until the matching `gnt`.
- `wdata0` in DATA_W — requester 0 write word. Must be stable while `req[0]` is high.
- `wdata1` in DATA_W — requester 1 write word. Same stability rule as `wdata0`.
- `gnt` out 2 — one-cycle registered grant pulse, one-hot.
- `done` out 2 — one-cycle pulse to the granted requester at end of frame.
- `rdata` out DATA_W — word captured from `miso` during the last frame.
- `busy` out 1 — high from grant until return to IDLE.
- `sclk` out 1 — SPI clock. Idle low.
- `ssn` out 1 — active-low slave select. Idle high.
- `mosi` out 1 — serial data out.
- `miso` in 1 — serial data in. Already synchronised externally.

## Operation
Reset values: `gnt=0`, `done=0`, `rdata=0`, `busy=0`, `sclk=0`, `ssn=1`, `mosi=0`. The round-robin pointer resets to "requester 0 preferred".

Reset mid-frame aborts the frame immediately:
- No `done` is issued and `rdata` is cleared.
- The requester must re-request.

States:
- **IDLE**
  - Arbitration is evaluated only in this state.
  - If any `req` bit is high: latch the winner's `wdata` into the shift register, record the winner, and go to SETUP.
  - Requests arriving while busy are held off until IDLE, never dropped by the block.
  - A request deasserted before its grant is simply not granted.
- **SETUP**
  - `gnt` is high for the first cycle only.
  - `ssn=0`, `sclk=0`, `mosi=shift[DATA_W-1]`, held for HALF cycles.
- **SHIFT**
  - Runs DATA_W bits. Each bit is HALF cycles with `sclk=1` followed by HALF cycles with `sclk=0`.
  - `miso` is sampled into the read shift register on the last cycle of each high phase.
  - At each falling edge the shift register shifts left and `mosi` takes the next bit.
  - After the last bit's low phase, go to GAP.
- **GAP**
  - `ssn=1`, `mosi=0`, held for GAP_CYC cycles.
  - On the first GAP cycle: `done[winner]` pulses and `rdata` updates.
  - Return to IDLE after GAP_CYC cycles. `busy` drops on entry to IDLE.

Counters and widths:
- Bit counter is 5 bits, covering 0..DATA_W.
- Divider counter is `$clog2(CLK_DIV)` bits and wraps at HALF-1.

## Timing
- Request to `gnt`: `req` seen high in IDLE at edge N gives `gnt` high during cycle N+1, with `ssn` falling in the same cycle.
- Frame length (`ssn` low): HALF + DATA_W·CLK_DIV cycles, i.e. 165 with defaults.
- First `sclk` rise occurs HALF cycles after `ssn` falls.
- `done` coincides with `ssn` rising.
- Back-to-back frames: the next `gnt` comes no earlier than GAP_CYC+1 cycles after `done`.
- Sustained throughput: one frame per HALF + DATA_W·CLK_DIV + GAP_CYC + 1 cycles, i.e. 168 with defaults.

## Configuration
Macro `SPI_ARB_RR_EN`:
- **Defined:** round-robin arbitration. When both request, the requester not granted last wins. A single requester always wins.
- **Undefined:** fixed priority, `req[0]` always beats `req[1]`, and the pointer logic is removed.

## Test plan
- **Single frame:** `req=01`, `wdata0=16'hA5C3`, `miso` tied to the bit pattern of 16'h3C5A.
  - `gnt=01` one cycle later.
  - `mosi` shows A5C3 MSB-first, one bit per 10 cycles.
  - `ssn` low for 165 cycles.
  - `done=01` with `rdata=16'h3C5A`.
- **Loopback:** `miso=mosi`, `wdata1=16'h8001` → `rdata=16'h8001`; `sclk` shows 16 rises, low at idle.
- **Contention:** `req=11` held continuously.
  - With `SPI_ARB_RR_EN`: grants alternate 01, 10, 01, …
  - Without it: 01 every frame.
  - In both builds, grants are spaced 168 cycles apart.
- **Request during busy:** `req[1]` rises mid-frame of requester 0 → no `gnt[1]` until GAP completes; then `gnt=10`.
- **Reset mid-frame:** `reset` pulsed during bit 7.
  - Next cycle: `ssn=1`, `sclk=0`, `busy=0`, `rdata=0`, and no `done`.
  - A subsequent `req=01` produces a full, correct frame.
